// File: rtl/decode_pkg.sv
// Shared encodings for the OP-IMM / OP-IMM-32 control decoder.
// Used by decode and decode_aluop.
package decode_pkg;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        S_IMM  = 3'd0,
        S_RS1  = 3'd1,
        S_EXEC = 3'd2,
        S_WAIT = 3'd3
    } ustate_e;

    typedef struct packed {
        logic cflag;
        logic sum_en;
        logic and_en;
        logic xor_en;
        logic invb_en;
        logic lsh_en;
        logic rsh_en;
        logic ltu_en;
        logic lts_en;
        logic sx32_en;
    } alu_en_t;

    typedef struct packed {
        logic       defined;
        logic       alub_imm6i;
        logic       alub_imm12;
        logic       ra_ir1;
        logic       ra_ird;
        logic       alua_rf;
        logic       rf_alu;
        logic [3:0] rmask;
        logic [2:0] nstate;
        alu_en_t    alu;
    } dec_out_t;

    // hi7 is ir[31:25]; the W forms only have a 5-bit shamt, so bit 25 joins the zero field.
    function automatic logic shift_legal(input logic [2:0] funct3,
                                         input logic       sx32,
                                         input logic [6:0] hi7);
        logic ok;
        ok = 1'b1;
        if (funct3 == F3_SLL)
            ok = sx32 ? (hi7 == 7'd0) : (hi7[6:1] == 6'd0);
        else if (funct3 == F3_SRL)
            ok = !hi7[6] && (sx32 ? (hi7[4:0] == 5'd0) : (hi7[4:1] == 4'd0));
        return ok;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Bundle between the IR/state register (master) and the decoder (slave).
interface decode_if;
    logic [2:0]  cstate_i;
    logic [31:0] ir_i;
    logic        defined_o;
    logic        alub_imm6i_o;
    logic        alub_imm12_o;
    logic        ra_ir1_o;
    logic        ra_ird_o;
    logic        alua_rf_o;
    logic        rf_alu_o;
    logic [3:0]  rmask_o;
    logic [2:0]  nstate_o;
    logic        cflag_1_o;
    logic        sum_en_o;
    logic        and_en_o;
    logic        xor_en_o;
    logic        invB_en_o;
    logic        lsh_en_o;
    logic        rsh_en_o;
    logic        ltu_en_o;
    logic        lts_en_o;
    logic        sx32_en_o;

    modport master (
        output cstate_i, ir_i,
        input  defined_o, alub_imm6i_o, alub_imm12_o, ra_ir1_o, ra_ird_o,
               alua_rf_o, rf_alu_o, rmask_o, nstate_o, cflag_1_o, sum_en_o,
               and_en_o, xor_en_o, invB_en_o, lsh_en_o, rsh_en_o, ltu_en_o,
               lts_en_o, sx32_en_o
    );

    modport slave (
        input  cstate_i, ir_i,
        output defined_o, alub_imm6i_o, alub_imm12_o, ra_ir1_o, ra_ird_o,
               alua_rf_o, rf_alu_o, rmask_o, nstate_o, cflag_1_o, sum_en_o,
               and_en_o, xor_en_o, invB_en_o, lsh_en_o, rsh_en_o, ltu_en_o,
               lts_en_o, sx32_en_o
    );
endinterface

// File: rtl/decode_aluop.sv
// funct3 -> ALU function enables for the integer-immediate group.
module decode_aluop
    import decode_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       arith_i,
    input  logic       sx32_i,
    output alu_en_t    alu_en_o
);

    // SLT/SLTU compute A + ~B + 1 and read the sign/carry; OR is built as AND + XOR.
    always_comb begin
        alu_en_o         = '0;
        alu_en_o.sx32_en = sx32_i;
        case (funct3_i)
            F3_ADD:  alu_en_o.sum_en = 1'b1;
            F3_SLL:  alu_en_o.lsh_en = 1'b1;
            F3_SLT: begin
                alu_en_o.cflag   = 1'b1;
                alu_en_o.invb_en = 1'b1;
                alu_en_o.lts_en  = 1'b1;
            end
            F3_SLTU: begin
                alu_en_o.cflag   = 1'b1;
                alu_en_o.invb_en = 1'b1;
                alu_en_o.ltu_en  = 1'b1;
            end
            F3_XOR:  alu_en_o.xor_en = 1'b1;
            F3_SRL: begin
                alu_en_o.rsh_en = 1'b1;
                alu_en_o.cflag  = arith_i;
            end
            F3_OR: begin
                alu_en_o.and_en = 1'b1;
                alu_en_o.xor_en = 1'b1;
            end
            F3_AND:  alu_en_o.and_en = 1'b1;
            default: alu_en_o = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV64I OP-IMM / OP-IMM-32 control decoder. Define DECODE_REG_OUT_EN to register
// every output on clk_i (reset_i clears them asynchronously); otherwise purely combinational.
//   state  | meaning
//   S_IMM  | steer immediate onto ALU B
//   S_RS1  | address rs1
//   S_EXEC | ALU op, write rd
//   S_WAIT | hold until next fetch
module decode
    import decode_pkg::*;
(
    input  logic    clk_i,
    input  logic    reset_i,
    decode_if.slave bus
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       sx32;
    logic       opc_ok;
    alu_en_t    alu_en;
    dec_out_t   dec_d;
    dec_out_t   dec_out;

    assign opcode = bus.ir_i[6:0];
    assign funct3 = bus.ir_i[14:12];
    assign sx32   = bus.ir_i[3];
    assign opc_ok = (opcode == OPC_OP_IMM) || (opcode == OPC_OP_IMM32);

    decode_aluop u_aluop (
        .funct3_i (funct3),
        .arith_i  (bus.ir_i[30]),
        .sx32_i   (sx32),
        .alu_en_o (alu_en)
    );

    always_comb begin
        dec_d         = '0;
        dec_d.defined = opc_ok && shift_legal(funct3, sx32, bus.ir_i[31:25])
                        && (bus.cstate_i <= S_WAIT);
        if (dec_d.defined) begin
            case (bus.cstate_i)
                S_IMM: begin
                    if (funct3 == F3_SLL || funct3 == F3_SRL)
                        dec_d.alub_imm6i = 1'b1;
                    else
                        dec_d.alub_imm12 = 1'b1;
                    dec_d.nstate = S_RS1;
                end
                S_RS1: begin
                    dec_d.ra_ir1 = 1'b1;
                    dec_d.nstate = S_EXEC;
                end
                S_EXEC: begin
                    dec_d.alua_rf = 1'b1;
                    dec_d.ra_ird  = 1'b1;
                    dec_d.rf_alu  = 1'b1;
                    dec_d.rmask   = 4'hF;
                    dec_d.alu     = alu_en;
                    dec_d.nstate  = S_WAIT;
                end
                S_WAIT:  dec_d.nstate = S_WAIT;
                default: dec_d.nstate = 3'd0;
            endcase
        end
    end

`ifdef DECODE_REG_OUT_EN
    dec_out_t dec_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) dec_q <= '0;
        else         dec_q <= dec_d;
    end

    assign dec_out = dec_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ir_i[24:15], bus.ir_i[11:7]};
`else
    assign dec_out = dec_d;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk_i, reset_i, bus.ir_i[24:15], bus.ir_i[11:7]};
`endif

    assign bus.defined_o    = dec_out.defined;
    assign bus.alub_imm6i_o = dec_out.alub_imm6i;
    assign bus.alub_imm12_o = dec_out.alub_imm12;
    assign bus.ra_ir1_o     = dec_out.ra_ir1;
    assign bus.ra_ird_o     = dec_out.ra_ird;
    assign bus.alua_rf_o    = dec_out.alua_rf;
    assign bus.rf_alu_o     = dec_out.rf_alu;
    assign bus.rmask_o      = dec_out.rmask;
    assign bus.nstate_o     = dec_out.nstate;
    assign bus.cflag_1_o    = dec_out.alu.cflag;
    assign bus.sum_en_o     = dec_out.alu.sum_en;
    assign bus.and_en_o     = dec_out.alu.and_en;
    assign bus.xor_en_o     = dec_out.alu.xor_en;
    assign bus.invB_en_o    = dec_out.alu.invb_en;
    assign bus.lsh_en_o     = dec_out.alu.lsh_en;
    assign bus.rsh_en_o     = dec_out.alu.rsh_en;
    assign bus.ltu_en_o     = dec_out.alu.ltu_en;
    assign bus.lts_en_o     = dec_out.alu.lts_en;
    assign bus.sx32_en_o    = dec_out.alu.sx32_en;

endmodule

// File: tb/tb_decode.sv
// Directed vector bench for decode; output word = {defined, ctl[5:0], rmask, nstate, alu[9:0]}.
module tb_decode;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    decode_if bus ();

    decode dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    // ctl = {imm6i, imm12, ra_ir1, ra_ird, alua_rf, rf_alu}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_IMM6 = 6'b100000;
    localparam logic [5:0] C_IMM12 = 6'b010000;
    localparam logic [5:0] C_RS1  = 6'b001000;
    localparam logic [5:0] C_EXEC = 6'b000111;
    // alu = {cflag, sum, and, xor, invB, lsh, rsh, ltu, lts, sx32}
    localparam logic [9:0] A_NONE = 10'b0000000000;
    localparam logic [9:0] A_ADD  = 10'b0100000000;
    localparam logic [9:0] A_SLL  = 10'b0000010000;
    localparam logic [9:0] A_SLT  = 10'b1000100010;
    localparam logic [9:0] A_SLTU = 10'b1000100100;
    localparam logic [9:0] A_XOR  = 10'b0001000000;
    localparam logic [9:0] A_SRL  = 10'b0000001000;
    localparam logic [9:0] A_SRA  = 10'b1000001000;
    localparam logic [9:0] A_OR   = 10'b0011000000;
    localparam logic [9:0] A_AND  = 10'b0010000000;
    localparam logic [9:0] A_SLLW = 10'b0000010001;
    localparam logic [9:0] A_SLTW = 10'b1000100011;
    localparam logic [23:0] ZERO  = 24'h000000;

    typedef struct {
        string       name;
        logic [2:0]  cst;
        logic [31:0] ir;
        logic [23:0] exp;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic logic [23:0] act_word();
        return {bus.defined_o, bus.alub_imm6i_o, bus.alub_imm12_o, bus.ra_ir1_o,
                bus.ra_ird_o, bus.alua_rf_o, bus.rf_alu_o, bus.rmask_o, bus.nstate_o,
                bus.cflag_1_o, bus.sum_en_o, bus.and_en_o, bus.xor_en_o, bus.invB_en_o,
                bus.lsh_en_o, bus.rsh_en_o, bus.ltu_en_o, bus.lts_en_o, bus.sx32_en_o};
    endfunction

    function automatic logic [23:0] mk(input logic d, input logic [5:0] c,
                                       input logic [3:0] m, input logic [2:0] n,
                                       input logic [9:0] a);
        return {d, c, m, n, a};
    endfunction

    task automatic check(input string name, input logic [23:0] exp);
        logic [23:0] act;
        act = act_word();
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Inputs change just after a rising edge; outputs are sampled after the next one,
    // which covers both the combinational and the registered build.
    task automatic apply(input logic [2:0] cs, input logic [31:0] ir);
        bus.cstate_i = cs;
        bus.ir_i     = ir;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"addi_s0",     3'd0, 32'h04200093, mk(1'b1, C_IMM12, 4'h0, 3'd1, A_NONE)};
        vecs[1]  = '{"slli_s0",     3'd0, 32'h00201093, mk(1'b1, C_IMM6,  4'h0, 3'd1, A_NONE)};
        vecs[2]  = '{"slli_s1",     3'd1, 32'h00201093, mk(1'b1, C_RS1,   4'h0, 3'd2, A_NONE)};
        vecs[3]  = '{"slli_s3",     3'd3, 32'h00201093, mk(1'b1, C_NONE,  4'h0, 3'd3, A_NONE)};
        vecs[4]  = '{"addi_s2",     3'd2, 32'h04200093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_ADD)};
        vecs[5]  = '{"slli_s2",     3'd2, 32'h00201093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_SLL)};
        vecs[6]  = '{"slti_s2",     3'd2, 32'h04202093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_SLT)};
        vecs[7]  = '{"sltiu_s2",    3'd2, 32'h04203093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_SLTU)};
        vecs[8]  = '{"xori_s2",     3'd2, 32'h04204093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_XOR)};
        vecs[9]  = '{"srli_s2",     3'd2, 32'h00205093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_SRL)};
        vecs[10] = '{"srai_s2",     3'd2, 32'h40205093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_SRA)};
        vecs[11] = '{"ori_s2",      3'd2, 32'h04206093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_OR)};
        vecs[12] = '{"andi_s2",     3'd2, 32'h04207093, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_AND)};
        vecs[13] = '{"srli_s0",     3'd0, 32'h00205093, mk(1'b1, C_IMM6,  4'h0, 3'd1, A_NONE)};
        vecs[14] = '{"slli_b25_ok", 3'd0, 32'h02001093, mk(1'b1, C_IMM6,  4'h0, 3'd1, A_NONE)};
        vecs[15] = '{"slli_b26",    3'd0, 32'h04201093, ZERO};
        vecs[16] = '{"slliw_b25",   3'd2, 32'h0220101B, ZERO};
        vecs[17] = '{"slliw_s2",    3'd2, 32'h0010101B, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_SLLW)};
        vecs[18] = '{"srai_b31",    3'd2, 32'hC0205093, ZERO};
        vecs[19] = '{"srai_b28",    3'd0, 32'h50205093, ZERO};
        vecs[20] = '{"sraiw_b25",   3'd2, 32'h4220501B, ZERO};
        vecs[21] = '{"sltiw_s2",    3'd2, 32'h0420201B, mk(1'b1, C_EXEC,  4'hF, 3'd3, A_SLTW)};
        vecs[22] = '{"op_reg",      3'd0, 32'h00000033, ZERO};
        vecs[23] = '{"cstate4",     3'd4, 32'h04200093, ZERO};
        vecs[24] = '{"cstate7",     3'd7, 32'h04200093, ZERO};

        bus.cstate_i = 3'd0;
        bus.ir_i     = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", ZERO);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].cst, vecs[i].ir);
            check(vecs[i].name, vecs[i].exp);
        end

`ifdef DECODE_REG_OUT_EN
        apply(3'd2, 32'h04200093);
        check("pre_reset", mk(1'b1, C_EXEC, 4'hF, 3'd3, A_ADD));
        #2 rst = 1'b1;
        #1 check("async_clear", ZERO);
        @(posedge clk);
        #1 check("held_in_reset", ZERO);
        bus.cstate_i = 3'd2;
        bus.ir_i     = 32'h0420201B;
        #2 rst = 1'b0;
        #1 check("released_no_edge", ZERO);
        @(posedge clk);
        #1 check("one_edge_later", mk(1'b1, C_EXEC, 4'hF, 3'd3, A_SLTW));
`else
        begin
            logic [23:0] seq_exp [4];
            logic [2:0]  cs;
            seq_exp[0] = mk(1'b1, C_IMM6, 4'h0, 3'd1, A_NONE);
            seq_exp[1] = mk(1'b1, C_RS1,  4'h0, 3'd2, A_NONE);
            seq_exp[2] = mk(1'b1, C_EXEC, 4'hF, 3'd3, A_SRA);
            seq_exp[3] = mk(1'b1, C_NONE, 4'h0, 3'd3, A_NONE);
            cs = 3'd0;
            for (int k = 0; k < 4; k++) begin
                apply(cs, 32'h40205093);
                check($sformatf("srai_seq%0d", k), seq_exp[k]);
                cs = bus.nstate_o;
            end
        end
        rst = 1'b1;
        apply(3'd2, 32'h04206093);
        check("reset_ignored", mk(1'b1, C_EXEC, 4'hF, 3'd3, A_OR));
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
